// File: rtl/adc_sample_buffer_if.sv
// adc_sample_buffer_if -- sample-in / FIFO-out bundle for adc_sample_buffer.
//   in_dat    : parallel sample from the ADC serial reader (bit 0 is the MSB)
//   in_rdy    : reader ready flag; a rising edge marks one completed sample
//   out_dat   : FIFO head word (first-word-fall-through)
//   out_valid : FIFO non-empty
//   out_ready : consumer accepts out_dat this cycle
//   level     : FIFO occupancy, 0..2^depth_log2
//   overflow  : sticky, set when an averaged word is dropped on a full FIFO
// slave = buffer side, master = reader/consumer side.
interface adc_sample_buffer_if #(
  parameter int datlen     = 12,
  parameter int depth_log2 = 4
);
  logic [0:datlen-1]   in_dat;
  logic                in_rdy;
  logic [0:datlen-1]   out_dat;
  logic                out_valid;
  logic                out_ready;
  logic [depth_log2:0] level;
  logic                overflow;

  modport slave (
    input  in_dat, in_rdy, out_ready,
    output out_dat, out_valid, level, overflow
  );

  modport master (
    output in_dat, in_rdy, out_ready,
    input  out_dat, out_valid, level, overflow
  );
endinterface

// File: rtl/adc_sample_buffer.sv
// adc_sample_buffer -- captures one sample per in_rdy rising edge, averages
// 2^avg_log2 samples into one word and queues it in a 2^depth_log2-deep
// first-word-fall-through FIFO.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : adc_sample_buffer_if.slave (sample input, FIFO output, level, overflow)
module adc_sample_buffer #(
  parameter int datlen     = 12,
  parameter int avg_log2   = 2,
  parameter int depth_log2 = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_sample_buffer_if.slave   bus
);

  localparam int AW    = datlen + avg_log2;
  localparam int CW    = (avg_log2 > 0) ? avg_log2 : 1;
  localparam int DEPTH = 1 << depth_log2;
  localparam logic [CW-1:0]       CNT_LAST = CW'((1 << avg_log2) - 1);
  localparam logic [depth_log2:0] LVL_FULL = (depth_log2 + 1)'(DEPTH);

  logic                  rdy_q;
  logic [AW-1:0]         acc;
  logic [CW-1:0]         cnt;
  logic [depth_log2-1:0] wptr, rptr;
  logic [depth_log2:0]   lvl;
  logic                  ovf;
  logic [datlen-1:0]     mem [DEPTH];

  logic                  cap, last, push, pop, full, wr;
  logic [AW-1:0]         sum;
  logic [datlen-1:0]     result;

  always_comb begin
    cap    = bus.in_rdy & ~rdy_q;
    // with avg_log2 = 0 cnt stays 0 and every capture completes a group
    last   = (cnt == CNT_LAST);
    sum    = acc + AW'(bus.in_dat);
    result = datlen'(sum >> avg_log2);
    push   = cap & last;
    full   = (lvl == LVL_FULL);
    pop    = bus.out_ready & (lvl != '0);
    // a pop on the same edge frees the slot, so a full FIFO still accepts
    wr     = push & (~full | pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= 1'b1;   // an in_rdy held across reset release is not an edge
      acc   <= '0;
      cnt   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      lvl   <= '0;
      ovf   <= 1'b0;
    end else begin
      rdy_q <= bus.in_rdy;
      if (cap) begin
        if (last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CW'(1);
        end
      end
      if (wr)  wptr <= wptr + depth_log2'(1);
      if (pop) rptr <= rptr + depth_log2'(1);
      case ({wr, pop})
        2'b10:   lvl <= lvl + (depth_log2 + 1)'(1);
        2'b01:   lvl <= lvl - (depth_log2 + 1)'(1);
        default: lvl <= lvl;
      endcase
      if (push & full & ~pop) ovf <= 1'b1;
    end
  end

  // storage is not reset; level gates visibility
  always_ff @(posedge clk) begin
    if (wr & ~rst) mem[wptr] <= result;
  end

  assign bus.out_dat   = mem[rptr];
  assign bus.out_valid = (lvl != '0);
  assign bus.level     = lvl;
  assign bus.overflow  = ovf;

endmodule

// File: tb/tb_adc_sample_buffer.sv
module tb_adc_sample_buffer;
  localparam int DL    = 12;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adc_sample_buffer_if #(.datlen(DL), .depth_log2(4)) ia ();
  adc_sample_buffer_if #(.datlen(DL), .depth_log2(4)) ib ();

  adc_sample_buffer #(.datlen(DL), .avg_log2(2), .depth_log2(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ia));
  adc_sample_buffer #(.datlen(DL), .avg_log2(0), .depth_log2(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ib));

  int checks = 0;
  int errors = 0;

  // scoreboard + reference model for dut_a (average of 4)
  int exp_q[$];
  int qb[$];
  int m_acc, m_cnt, m_lev;
  bit m_ovf;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear;
    m_acc = 0; m_cnt = 0; m_lev = 0; m_ovf = 0;
    exp_q.delete();
    qb.delete();
  endfunction

  function automatic void model_cap(int v, bit pop);
    bit full_b, popped;
    int w;
    full_b = (m_lev == DEPTH);
    popped = pop && (m_lev > 0);
    if (popped) begin
      void'(exp_q.pop_front());
      m_lev--;
    end
    if (m_cnt < 3) begin
      m_acc += v;
      m_cnt++;
    end else begin
      w = (m_acc + v) >> 2;
      m_acc = 0;
      m_cnt = 0;
      if (full_b && !popped) m_ovf = 1;
      else begin
        exp_q.push_back(w);
        m_lev++;
      end
    end
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    ia.in_rdy = 1'b0; ia.out_ready = 1'b0;
    ib.in_rdy = 1'b0; ib.out_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
    tick;   // let rdy_q settle low before the first capture
    model_clear();
  endtask

  task automatic cap(int v, bit pop);
    ia.in_dat = DL'(v);
    ia.in_rdy = 1'b1;
    ia.out_ready = pop;
    tick;
    model_cap(v, pop);
    ia.in_rdy = 1'b0;
    ia.out_ready = 1'b0;
    tick;
  endtask

  // scoreboard consumer: pop every word the DUT offers, compare in order
  task automatic drain(string nm);
    int e;
    ia.out_ready = 1'b1;
    for (int i = 0; i < 40 && ia.out_valid === 1'b1; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s_extra got %0d want none", nm, ia.out_dat);
      end else begin
        e = exp_q.pop_front();
        if (ia.out_dat !== DL'(e)) begin
          errors++;
          $display("FAIL %s_word got %0d want %0d", nm, ia.out_dat, e);
        end
      end
      tick;
    end
    ia.out_ready = 1'b0;
    m_lev = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing got %0d words left want 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (ia.out_valid !== 1'b0 || ia.level !== 5'd0 || ia.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%b l=%0d o=%b want 0 0 0",
               ia.out_valid, ia.level, ia.overflow);
    end
  endtask

  task automatic test_basic;
    do_reset();
    cap(100, 0); cap(200, 0); cap(300, 0);
    checks++;
    if (ia.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got valid=%b want 0", ia.out_valid);
    end
    ia.in_dat = DL'(400);
    ia.in_rdy = 1'b1;
    tick;
    model_cap(400, 0);
    checks++;
    if (ia.out_valid !== 1'b1 || ia.out_dat !== DL'(250) || ia.level !== 5'd1) begin
      errors++;
      $display("FAIL basic_push got v=%b d=%0d l=%0d want 1 250 1",
               ia.out_valid, ia.out_dat, ia.level);
    end
    ia.in_rdy = 1'b0;
    tick;
    drain("basic");
  endtask

  task automatic test_held;
    do_reset();
    ia.in_dat = DL'(8);
    ia.in_rdy = 1'b1;
    repeat (5) tick;
    ia.in_rdy = 1'b0;
    tick;
    model_cap(8, 0);
    repeat (3) cap(8, 0);
    checks++;
    if (ia.level !== 5'd1) begin
      errors++;
      $display("FAIL held_level got %0d want 1", ia.level);
    end
    drain("held");
  endtask

  task automatic test_overflow;
    do_reset();
    for (int n = 1; n <= 17; n++) repeat (4) cap(n, 0);
    checks++;
    if (ia.level !== 5'd16 || ia.overflow !== 1'b1 || ia.out_dat !== DL'(1)) begin
      errors++;
      $display("FAIL ovf_state got l=%0d o=%b h=%0d want 16 1 1",
               ia.level, ia.overflow, ia.out_dat);
    end
    drain("ovf");
    checks++;
    if (ia.overflow !== 1'b1 || ia.level !== 5'd0) begin
      errors++;
      $display("FAIL ovf_sticky got o=%b l=%0d want 1 0", ia.overflow, ia.level);
    end
  endtask

  task automatic test_full_pop;
    do_reset();
    for (int n = 1; n <= 16; n++) repeat (4) cap(n, 0);
    repeat (3) cap(17, 0);
    checks++;
    if (ia.out_dat !== DL'(exp_q[0])) begin
      errors++;
      $display("FAIL fullpop_head got %0d want %0d", ia.out_dat, exp_q[0]);
    end
    cap(17, 1);
    checks++;
    if (ia.level !== 5'd16 || ia.overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_state got l=%0d o=%b want 16 0", ia.level, ia.overflow);
    end
    drain("fullpop");
  endtask

  task automatic test_reset_full;
    do_reset();
    for (int n = 1; n <= 16; n++) repeat (4) cap(n + 100, 0);
    do_reset();
    checks++;
    if (ia.out_valid !== 1'b0 || ia.level !== 5'd0 || ia.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstfull_state got v=%b l=%0d o=%b want 0 0 0",
               ia.out_valid, ia.level, ia.overflow);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    cap(1000, 0); cap(1000, 0);
    rst = 1'b1;
    ia.in_dat = DL'(999);
    ia.in_rdy = 1'b1; tick;
    ia.in_rdy = 1'b0; tick;
    ia.in_rdy = 1'b1; tick;   // edge during reset
    rst = 1'b0;
    tick;                     // still high at release: not a capture
    ia.in_rdy = 1'b0;
    tick;
    model_clear();
    repeat (4) cap(40, 0);
    checks++;
    if (ia.level !== 5'd1 || ia.overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state got l=%0d o=%b want 1 0", ia.level, ia.overflow);
    end
    drain("rstmid");
  endtask

  task automatic test_avg0;
    int vals[3] = '{4095, 0, 2048};
    int e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ib.in_dat = DL'(vals[i]);
      ib.in_rdy = 1'b1;
      qb.push_back(vals[i]);
      tick;
      e = qb.pop_front();
      checks++;
      if (ib.out_valid !== 1'b1 || ib.out_dat !== DL'(e)) begin
        errors++;
        $display("FAIL avg0_word got v=%b d=%0d want 1 %0d", ib.out_valid, ib.out_dat, e);
      end
      ib.in_rdy = 1'b0;
      ib.out_ready = 1'b1;
      tick;
      ib.out_ready = 1'b0;
      checks++;
      if (ib.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL avg0_pop got valid=%b want 0", ib.out_valid);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ia.in_dat = '0; ia.in_rdy = 1'b0; ia.out_ready = 1'b0;
    ib.in_dat = '0; ib.in_rdy = 1'b0; ib.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_held();
    test_overflow();
    test_full_pop();
    test_reset_full();
    test_reset_mid();
    test_avg0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_sample_buffer.md
ADC_SAMPLE_BUFFER -- requirements
Module: adc_sample_buffer

Interface
REQ-001 The block SHALL have parameter datlen, default 12, the sample width delivered by the upstream ADC serial reader.
REQ-002 The block SHALL have parameter avg_log2, default 2; 2^avg_log2 captured samples are averaged into one stored word (0 = pass-through).
REQ-003 The block SHALL have parameter depth_log2, default 4; FIFO depth is 2^depth_log2 words.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_dat, input, datlen: parallel sample from the reader, bit 0 is the MSB.
REQ-007 Port in_rdy, input, 1: reader ready flag; high for one or more cycles per completed sample.
REQ-008 Port out_dat, output, datlen: FIFO head word, first-word-fall-through.
REQ-009 Port out_valid, output, 1: FIFO non-empty.
REQ-010 Port out_ready, input, 1: consumer accepts out_dat this cycle.
REQ-011 Port level, output, depth_log2+1: current FIFO occupancy, 0..2^depth_log2.
REQ-012 Port overflow, output, 1: sticky flag, set when an averaged word is dropped.

Function
REQ-013 Capture SHALL occur only on an in_rdy rising edge (in_rdy=1 and registered rdy_q=0); a held-high in_rdy SHALL yield exactly one capture.
REQ-014 The accumulator SHALL be datlen+avg_log2 bits wide, unsigned; no capture can overflow it.
REQ-015 Per capture: if sample count < 2^avg_log2-1, acc += in_dat and count increments.
REQ-016 On the capture completing a group: result = (acc + in_dat) >> avg_log2 (truncating), acc and count clear to 0, and a push of result is issued in that same cycle.
REQ-017 Push latency: pushed word SHALL be visible on out_dat with out_valid=1 in the cycle after the completing capture, when the FIFO was empty.
REQ-018 Pop SHALL occur when out_valid=1 and out_ready=1; out_ready while empty has no effect.
REQ-019 Push while full and no pop: word is dropped, level stays 2^depth_log2, overflow set to 1 and held until reset.
REQ-020 Simultaneous push and pop while full: push SHALL be accepted, level unchanged, overflow unchanged.
REQ-021 Simultaneous push and pop while non-empty and non-full: level unchanged, FIFO order preserved.
REQ-022 Push while empty with out_ready=1: no pop that cycle; word becomes head next cycle.
REQ-023 Read and write pointers SHALL be depth_log2 bits and wrap modulo 2^depth_log2; level tracks occupancy separately.
REQ-024 With avg_log2=0, every capture SHALL push in_dat unchanged.
REQ-025 out_dat SHALL be don't-care while out_valid=0; verification SHALL not check it then.

Reset
REQ-026 While rst=1 at a clock edge: pointers, level, acc, count, overflow cleared to 0; out_valid=0 from the next cycle.
REQ-027 rdy_q SHALL reset to 1, so an in_rdy already high at reset release is not captured.
REQ-028 Reset mid-group SHALL discard the partial accumulation; reset with a full FIFO SHALL discard all stored words.
REQ-029 in_rdy edges during reset SHALL be ignored.

Verification
REQ-030 Defaults; captures of 100, 200, 300, 400 -> out_dat=250, out_valid=1 one cycle after the 4th capture, level=1.
REQ-031 in_rdy held high 5 cycles with in_dat=8, then three single-cycle pulses of 8 -> exactly one word 8, not two.
REQ-032 out_ready=0; 17 groups of 4x(n) for n=1..17 -> level=16, overflow=1, head=1; drain yields 1..16 in order.
REQ-033 FIFO full, out_ready=1 held, one more group completes -> level stays 16, overflow=0, the new word is last out.
REQ-034 Two captures of 1000, rst pulse one cycle, then four captures of 40 -> single word 40, overflow=0.
REQ-035 avg_log2=0; captures 4095, 0, 2048 -> out words 4095, 0, 2048 in order, each one cycle after capture.
